tlk2711_axil_reg_bridge: RTL

- AXI4-Lite slave that converts PS register transactions into the TLK2711 simple register bus: write-enable/address/data and read-enable/address with fixed-latency read data.
- Sits directly upstream of the TLK2711 top-level register port, in the ps_clk domain.
- Drives the register-bus inputs of that port and consumes its read-data output.
- Write and read channels are independent and may be in flight at the same time.

---
 rtl/tlk2711_pkg.sv | 29 ++
 rtl/tlk2711_axil_reg_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_pkg
// Description : Shared constants and FSM state types for the TLK2711 register
//               bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package tlk2711_pkg;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

    localparam int         REG_ADDR_WIDTH = 16;
    localparam int         REG_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage : tlk2711_pkg
`default_nettype wire

// File: rtl/tlk2711_axil_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_axil_reg_bridge
// Description : AXI4-Lite slave converting PS register accesses into the
//               TLK2711 strobe/address/data register bus (fixed read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_axil_reg_bridge
    import tlk2711_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       ps_clk,
    input  logic                       ps_rst,

    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [REG_DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [7:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,

    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [REG_DATA_WIDTH-1:0]  s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,

    output logic                       o_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]  o_reg_waddr,
    output logic [REG_DATA_WIDTH-1:0]  o_reg_wdata,
    output logic                       o_reg_ren,
    output logic [REG_ADDR_WIDTH-1:0]  o_reg_raddr,
    input  logic [REG_DATA_WIDTH-1:0]  i_reg_rdata
);

    localparam int         RD_CNT_WIDTH = 3;
    localparam logic [RD_CNT_WIDTH-1:0] RD_CNT_INIT = RD_CNT_WIDTH'(RD_LATENCY);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t                   r_wr_state;
    logic                        r_awready;
    logic                        r_wready;
    logic [REG_ADDR_WIDTH-1:0]   r_aw_addr;
    logic                        r_aw_ok;
    logic [REG_DATA_WIDTH-1:0]   r_w_data;
    logic                        r_w_ok;
    logic                        r_wen;
    logic [REG_ADDR_WIDTH-1:0]   r_waddr;
    logic [REG_DATA_WIDTH-1:0]   r_wdata;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;

    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic                        w_aw_have;
    logic                        w_w_have;
    logic [REG_ADDR_WIDTH-1:0]   w_aw_addr_eff;
    logic                        w_aw_ok_eff;
    logic [REG_DATA_WIDTH-1:0]   w_w_data_eff;
    logic                        w_w_ok_eff;
    logic                        w_wr_legal;

    assign w_aw_hs       = s_axil_awvalid && r_awready;
    assign w_w_hs        = s_axil_wvalid  && r_wready;
    // A dropped ready in W_IDLE means that half has already been latched.
    assign w_aw_have     = w_aw_hs || !r_awready;
    assign w_w_have      = w_w_hs  || !r_wready;
    assign w_aw_addr_eff = w_aw_hs ? s_axil_awaddr[REG_ADDR_WIDTH-1:0] : r_aw_addr;
    assign w_aw_ok_eff   = w_aw_hs ? (s_axil_awaddr[2:0] == 3'd0) : r_aw_ok;
    assign w_w_data_eff  = w_w_hs  ? s_axil_wdata : r_w_data;
    assign w_w_ok_eff    = w_w_hs  ? (s_axil_wstrb == 8'hFF) : r_w_ok;
    assign w_wr_legal    = w_aw_ok_eff && w_w_ok_eff;

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_aw_addr  <= '0;
            r_aw_ok    <= 1'b0;
            r_w_data   <= '0;
            r_w_ok     <= 1'b0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wen <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_addr <= s_axil_awaddr[REG_ADDR_WIDTH-1:0];
                        r_aw_ok   <= (s_axil_awaddr[2:0] == 3'd0);
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_w_data <= s_axil_wdata;
                        r_w_ok   <= (s_axil_wstrb == 8'hFF);
                        r_wready <= 1'b0;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_wen <= w_wr_legal;
                        if (w_wr_legal) begin
                            r_waddr <= w_aw_addr_eff;
                            r_wdata <= w_w_data_eff;
                        end
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_legal ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= W_EXEC;
                    end
                end
                // bvalid is already visible in W_EXEC, so bready there completes the response.
                W_EXEC, W_RESP: begin
                    if (s_axil_bready) begin
                        r_bvalid   <= 1'b0;
                        r_bresp    <= RESP_OKAY;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end else begin
                        r_wr_state <= W_RESP;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t                   r_rd_state;
    logic                        r_arready;
    logic                        r_rd_ok;
    logic                        r_ren;
    logic [REG_ADDR_WIDTH-1:0]   r_raddr;
    logic [RD_CNT_WIDTH-1:0]     r_rd_cnt;
    logic                        r_rvalid;
    logic [1:0]                  r_rresp;
    logic                        r_rd_first;
    logic [REG_DATA_WIDTH-1:0]   r_rdata;

    logic                        w_ar_hs;
    logic                        w_ar_ok;
    logic [REG_DATA_WIDTH-1:0]   w_rdata_live;

    assign w_ar_hs      = s_axil_arvalid && r_arready;
    assign w_ar_ok      = (s_axil_araddr[2:0] == 3'd0);
    assign w_rdata_live = r_rd_ok ? i_reg_rdata : '0;

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b1;
            r_rd_ok    <= 1'b0;
            r_ren      <= 1'b0;
            r_raddr    <= '0;
            r_rd_cnt   <= '0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rd_first <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ren <= 1'b0;
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready  <= 1'b0;
                        r_rd_ok    <= w_ar_ok;
                        r_ren      <= w_ar_ok;
                        if (w_ar_ok) begin
                            r_raddr <= s_axil_araddr[REG_ADDR_WIDTH-1:0];
                        end
                        r_rd_cnt   <= RD_CNT_INIT;
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rd_cnt == RD_CNT_WIDTH'(1)) begin
                        r_rvalid   <= 1'b1;
                        r_rresp    <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rd_first <= 1'b1;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - RD_CNT_WIDTH'(1);
                    end
                end
                R_RESP: begin
                    // Read data is only valid for one cycle downstream; freeze it here.
                    r_rd_first <= 1'b0;
                    if (r_rd_first) begin
                        r_rdata <= w_rdata_live;
                    end
                    if (s_axil_rready) begin
                        r_rvalid   <= 1'b0;
                        r_rresp    <= RESP_OKAY;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    generate
        if (AXIL_ADDR_WIDTH > REG_ADDR_WIDTH) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{s_axil_awaddr[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH],
                                        s_axil_araddr[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH]};
        end
    endgenerate

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rd_first ? w_rdata_live : r_rdata;
    assign o_reg_wen      = r_wen;
    assign o_reg_waddr    = r_waddr;
    assign o_reg_wdata    = r_wdata;
    assign o_reg_ren      = r_ren;
    assign o_reg_raddr    = r_raddr;

endmodule : tlk2711_axil_reg_bridge
`default_nettype wire
